// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: PC in, instruction/stall out, and the line-fill
// request/burst channel toward instruction memory.
interface instr_fetch_if;
  logic [31:0] PC;
  logic        invalidate;
  logic [31:0] instr;
  logic        fetch_stall;
  logic        misaligned;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  PC, invalidate, mem_gnt, mem_rvalid, mem_rdata,
    output instr, fetch_stall, misaligned, mem_req, mem_addr
  );

  modport slave (
    output PC, invalidate, mem_gnt, mem_rvalid, mem_rdata,
    input  instr, fetch_stall, misaligned, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage with a single-line instruction buffer; a miss pulls one aligned
// line from memory via req/gnt followed by an rvalid burst.
//
// state | meaning
// IDLE  | serving hits from the buffer, launching a fill on a miss
// REQ   | mem_req held high until mem_gnt
// FILL  | collecting LINE_WORDS beats into the buffer
module instr_fetch_unit #(
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF   = CNT_W + 2;
  localparam int TAG_W = 32 - OFF;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t             state;
  logic [31:0]        line_data [LINE_WORDS];
  logic [TAG_W-1:0]   tag_q;
  logic               valid;
  logic               inval_pend;
  logic [CNT_W-1:0]   beat_cnt;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;

  logic [TAG_W-1:0]   pc_tag;
  logic [CNT_W-1:0]   pc_idx;
  logic               misal;
  logic               hit;

  assign pc_tag = bus.PC[31:OFF];
  assign pc_idx = bus.PC[OFF-1:2];
  assign misal  = |bus.PC[1:0];
  assign hit    = valid && (tag_q == pc_tag);

  assign bus.misaligned = misal;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

  always_comb begin
    bus.instr       = NOP_INSTR;
    bus.fetch_stall = 1'b1;
    if (!rst && state == IDLE) begin
      if (misal) begin
        bus.fetch_stall = 1'b0;
      end else if (hit) begin
        bus.instr       = line_data[pc_idx];
        bus.fetch_stall = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= 1'b0;
      inval_pend <= 1'b0;
      beat_cnt   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          inval_pend <= 1'b0;
          if (bus.invalidate) valid <= 1'b0;
          if (!misal && !hit) begin
            mem_addr_q <= {pc_tag, {OFF{1'b0}}};
            mem_req_q  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.invalidate) inval_pend <= 1'b1;
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (bus.invalidate) inval_pend <= 1'b1;
          if (bus.mem_rvalid) begin
            line_data[beat_cnt] <= bus.mem_rdata;
            beat_cnt            <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              // An invalidate on the final beat counts as pending too.
              tag_q <= mem_addr_q[31:OFF];
              valid <= !(inval_pend || bus.invalidate);
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: the bench plays instruction memory
// with scripted gnt/rvalid timing and checks outputs at the falling edge.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_if bus ();

  instr_fetch_unit #(.LINE_WORDS(4), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset_fill();
    rst = 1'b1;
    bus.PC = 32'h0; bus.invalidate = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    nxt(); nxt();
    smp();
    checks++;
    if (bus.instr !== NOP || bus.fetch_stall !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: instr=%h stall=%b req=%b, expected %h 1 0",
               bus.instr, bus.fetch_stall, bus.mem_req, NOP);
    end
    nxt();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.mem_gnt    = (c == 1);
      bus.mem_rvalid = (c >= 2);
      bus.mem_rdata  = 32'(32'hA0 + c - 2);
      smp();
      checks++;
      if (bus.fetch_stall !== 1'b1 || bus.mem_req !== (c == 1)) begin
        errors++;
        $display("FAIL fill0_cycle%0d: stall=%b req=%b, expected 1 %b",
                 c, bus.fetch_stall, bus.mem_req, (c == 1));
      end
      if (c == 1) begin
        checks++;
        if (bus.mem_addr !== 32'h0) begin
          errors++;
          $display("FAIL fill0_addr: got %h expected 00000000", bus.mem_addr);
        end
      end
      nxt();
    end
    bus.mem_rvalid = 1'b0;
    smp();
    checks++;
    if (bus.instr !== 32'hA0 || bus.fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL fill0_first_hit: instr=%h stall=%b, expected 000000a0 0",
               bus.instr, bus.fetch_stall);
    end
    nxt();
  endtask

  task automatic test_hits();
    for (int i = 1; i < 4; i++) begin
      bus.PC = 32'(4 * i);
      smp();
      checks++;
      if (bus.instr !== 32'(32'hA0 + i) || bus.fetch_stall !== 1'b0 ||
          bus.mem_req !== 1'b0 || bus.misaligned !== 1'b0) begin
        errors++;
        $display("FAIL hit_word%0d: instr=%h stall=%b req=%b mis=%b, expected %h 0 0 0",
                 i, bus.instr, bus.fetch_stall, bus.mem_req, bus.misaligned, 32'(32'hA0 + i));
      end
      nxt();
    end
  endtask

  task automatic test_gnt_delay();
    bus.PC = 32'h10;
    for (int c = 0; c < 10; c++) begin
      bus.mem_gnt    = (c == 4);
      bus.mem_rvalid = (c >= 5 && c <= 8);
      bus.mem_rdata  = 32'(32'hB0 + c - 5);
      smp();
      checks++;
      if (bus.fetch_stall !== (c < 9) || bus.mem_req !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL gnt_delay_cycle%0d: stall=%b req=%b, expected %b %b",
                 c, bus.fetch_stall, bus.mem_req, (c < 9), (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (bus.mem_addr !== 32'h10) begin
          errors++;
          $display("FAIL gnt_delay_addr%0d: got %h expected 00000010", c, bus.mem_addr);
        end
      end
      if (c == 9) begin
        checks++;
        if (bus.instr !== 32'hB0) begin
          errors++;
          $display("FAIL gnt_delay_hit: got %h expected 000000b0", bus.instr);
        end
      end
      nxt();
    end
  endtask

  task automatic test_invalidate_fill();
    bus.PC = 32'h20;
    for (int c = 0; c < 13; c++) begin
      bus.mem_gnt    = (c == 1 || c == 7);
      bus.mem_rvalid = (c >= 2 && c <= 5) || (c >= 8 && c <= 11);
      bus.mem_rdata  = (c <= 5) ? 32'(32'hC0 + c - 2) : 32'(32'hD0 + c - 8);
      bus.invalidate = (c == 3);
      smp();
      checks++;
      if (bus.fetch_stall !== (c < 12) || bus.mem_req !== (c == 1 || c == 7)) begin
        errors++;
        $display("FAIL inval_fill_cycle%0d: stall=%b req=%b, expected %b %b",
                 c, bus.fetch_stall, bus.mem_req, (c < 12), (c == 1 || c == 7));
      end
      if (c == 7) begin
        checks++;
        if (bus.mem_addr !== 32'h20) begin
          errors++;
          $display("FAIL inval_refetch_addr: got %h expected 00000020", bus.mem_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.instr !== NOP) begin
          errors++;
          $display("FAIL inval_remiss_instr: got %h expected %h", bus.instr, NOP);
        end
      end
      if (c == 12) begin
        checks++;
        if (bus.instr !== 32'hD0) begin
          errors++;
          $display("FAIL inval_refill_hit: got %h expected 000000d0", bus.instr);
        end
      end
      nxt();
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] pcs [2];
    pcs[0] = 32'h6;
    pcs[1] = 32'h26;
    for (int i = 0; i < 2; i++) begin
      bus.PC = pcs[i];
      for (int c = 0; c < 2; c++) begin
        smp();
        checks++;
        if (bus.misaligned !== 1'b1 || bus.instr !== NOP ||
            bus.fetch_stall !== 1'b0 || bus.mem_req !== 1'b0) begin
          errors++;
          $display("FAIL misaligned_pc%h: mis=%b instr=%h stall=%b req=%b, expected 1 %h 0 0",
                   pcs[i], bus.misaligned, bus.instr, bus.fetch_stall, bus.mem_req, NOP);
        end
        nxt();
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.PC = 32'h40;
    for (int c = 0; c < 12; c++) begin
      rst            = (c == 4);
      bus.mem_gnt    = (c == 1 || c == 6);
      bus.mem_rvalid = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
      bus.mem_rdata  = (c <= 5) ? 32'(32'hE0 + c - 2) : 32'(32'hF0 + c - 7);
      smp();
      checks++;
      if (bus.fetch_stall !== (c < 11) || bus.mem_req !== (c == 1 || c == 6)) begin
        errors++;
        $display("FAIL rst_fill_cycle%0d: stall=%b req=%b, expected %b %b",
                 c, bus.fetch_stall, bus.mem_req, (c < 11), (c == 1 || c == 6));
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (bus.instr !== NOP) begin
          errors++;
          $display("FAIL rst_fill_instr%0d: got %h expected %h", c, bus.instr, NOP);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.mem_addr !== 32'h40) begin
          errors++;
          $display("FAIL rst_refetch_addr: got %h expected 00000040", bus.mem_addr);
        end
      end
      if (c == 11) begin
        checks++;
        if (bus.instr !== 32'hF0) begin
          errors++;
          $display("FAIL rst_refill_hit: got %h expected 000000f0", bus.instr);
        end
      end
      nxt();
    end
    bus.PC = 32'h4C;
    smp();
    checks++;
    if (bus.instr !== 32'hF3 || bus.fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_refill_last: instr=%h stall=%b, expected 000000f3 0",
               bus.instr, bus.fetch_stall);
    end
    nxt();
  endtask

  task automatic test_invalidate_idle();
    bus.PC = 32'h44;
    bus.invalidate = 1'b1;
    smp();
    checks++;
    if (bus.instr !== 32'hF1 || bus.fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL inval_idle_same: instr=%h stall=%b, expected 000000f1 0",
               bus.instr, bus.fetch_stall);
    end
    nxt();
    bus.invalidate = 1'b0;
    smp();
    checks++;
    if (bus.instr !== NOP || bus.fetch_stall !== 1'b1) begin
      errors++;
      $display("FAIL inval_idle_next: instr=%h stall=%b, expected %h 1",
               bus.instr, bus.fetch_stall, NOP);
    end
    nxt();
    smp();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL inval_idle_req: req=%b addr=%h, expected 1 00000040",
               bus.mem_req, bus.mem_addr);
    end
    nxt();
  endtask

  initial begin
    test_reset_fill();
    test_hits();
    test_gnt_delay();
    test_invalidate_fill();
    test_misaligned();
    test_reset_mid_fill();
    test_invalidate_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
